// File: rtl/bakraid_textram_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// bakraid_text_pkg
//   Shared constants and types for the Bakraid text-layer RAM controller.
//   - SEL_* : 68k region decode (CPU_SEL values)
//   - VRAM_WORDS / AUX_WORDS : depths of the text VRAM and select/scroll RAMs
//   - cpu_state_e : 68k-side access FSM states
// ----------------------------------------------------------------------------
package bakraid_text_pkg;

   localparam logic [1:0] SEL_VRAM   = 2'd0;
   localparam logic [1:0] SEL_SELECT = 2'd1;
   localparam logic [1:0] SEL_SCROLL = 2'd2;
   localparam logic [1:0] SEL_NONE   = 2'd3;

   localparam int unsigned VRAM_WORDS = 4096;
   localparam int unsigned AUX_WORDS  = 256;

   typedef enum logic [2:0] {
      StIdle,
      StAccess,
      StWait,
      StAck,
      StHold,
      StClear
   } cpu_state_e;

endpackage

// File: rtl/bakraid_textram_ctrl_if.sv
// ----------------------------------------------------------------------------
// bakraid_textram_ctrl_if
//   68k-side REQ/ACK bus into the text RAM controller.
//   master : the 68k bridge (drives REQ/RNW/SEL/ADDR/BE/DIN, samples DOUT/ACK)
//   slave  : the controller (samples request, drives DOUT/ACK)
// ----------------------------------------------------------------------------
interface bakraid_textram_ctrl_if #(
   parameter int unsigned AW = 12,
   parameter int unsigned DW = 16
);

   logic              CPU_REQ;
   logic              CPU_RNW;
   logic [1:0]        CPU_SEL;
   logic [AW-1:0]     CPU_ADDR;
   logic [DW/8-1:0]   CPU_BE;
   logic [DW-1:0]     CPU_DIN;
   logic [DW-1:0]     CPU_DOUT;
   logic              CPU_ACK;

   modport master (
      output CPU_REQ, CPU_RNW, CPU_SEL, CPU_ADDR, CPU_BE, CPU_DIN,
      input  CPU_DOUT, CPU_ACK
   );

   modport slave (
      input  CPU_REQ, CPU_RNW, CPU_SEL, CPU_ADDR, CPU_BE, CPU_DIN,
      output CPU_DOUT, CPU_ACK
   );

endinterface

// File: rtl/bakraid_textram_ctrl_bram_be.sv
// ----------------------------------------------------------------------------
// bakraid_bram_be
//   True dual-port RAM, registered outputs on both ports, byte enables on
//   port B, old-data read-during-write.
//   CLK96, RESET96_N : clock / async active-low reset (output registers only)
//   a_we, a_addr, a_din, a_dout          : port A (full-word write)
//   b_we, b_be, b_addr, b_din, b_dout    : port B (byte-masked write)
// ----------------------------------------------------------------------------
module bakraid_bram_be #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 16
) (
   input  logic              CLK96,
   input  logic              RESET96_N,
   input  logic              a_we,
   input  logic [AW-1:0]     a_addr,
   input  logic [DW-1:0]     a_din,
   output logic [DW-1:0]     a_dout,
   input  logic              b_we,
   input  logic [DW/8-1:0]   b_be,
   input  logic [AW-1:0]     b_addr,
   input  logic [DW-1:0]     b_din,
   output logic [DW-1:0]     b_dout
);

   logic [DW-1:0] mem [2**AW];

   // Array has no reset; port B wins if both ports write the same word.
   always_ff @(posedge CLK96) begin
      if (a_we) begin
         mem[a_addr] <= a_din;
      end
      if (b_we) begin
         for (int i = 0; i < DW/8; i++) begin
            if (b_be[i]) begin
               mem[b_addr][i*8 +: 8] <= b_din[i*8 +: 8];
            end
         end
      end
   end

   // Reads sample the array before this edge's writes land: old data.
   always_ff @(posedge CLK96 or negedge RESET96_N) begin
      if (!RESET96_N) begin
         a_dout <= '0;
         b_dout <= '0;
      end else begin
         a_dout <= mem[a_addr];
         b_dout <= mem[b_addr];
      end
   end

endmodule

// File: rtl/bakraid_textram_ctrl.sv
// ----------------------------------------------------------------------------
// bakraid_textram_ctrl
//   Owns text VRAM (4096x16), text select RAM (256x16) and text scroll RAM
//   (256x16). Port A of each RAM serves the line renderer with a fixed 2-cycle
//   latency; port B serves the 68k through a REQ/ACK handshake, and is also
//   used by the power-up clear sweep.
//   CLK96, RESET96_N                   : clock, async active-low reset
//   TEXTVRAM_ADDR / TEXTVRAM_DATA      : renderer VRAM read port
//   TEXTSELECT_ADDR / TEXTSELECT_DATA  : renderer select-RAM read port
//   TEXTSCROLL_ADDR / TEXTSCROLL_DATA  : renderer scroll-RAM read port
//   cpu                                : 68k REQ/ACK bus (slave side)
//   CLEAR_BUSY                         : high while the clear sweep runs
// ----------------------------------------------------------------------------
module bakraid_textram_ctrl
   import bakraid_text_pkg::*;
#(
   parameter int unsigned VRAM_AW        = 12,
   parameter int unsigned AUX_AW         = 8,
   parameter int unsigned DW             = 16,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                  CLK96,
   input  logic                  RESET96_N,
   input  logic [VRAM_AW-1:0]    TEXTVRAM_ADDR,
   output logic [DW-1:0]         TEXTVRAM_DATA,
   input  logic [AUX_AW-1:0]     TEXTSELECT_ADDR,
   output logic [DW-1:0]         TEXTSELECT_DATA,
   input  logic [AUX_AW-1:0]     TEXTSCROLL_ADDR,
   output logic [DW-1:0]         TEXTSCROLL_DATA,
   bakraid_textram_ctrl_if.slave cpu,
   output logic                  CLEAR_BUSY
);

   localparam int unsigned         BW          = DW / 8;
   localparam cpu_state_e          RESET_STATE = CLEAR_ON_RESET ? StClear : StIdle;
   localparam logic [VRAM_AW-1:0]  CNT_LAST    = VRAM_AW'(VRAM_WORDS - 1);
   localparam logic [VRAM_AW-1:0]  CNT_AUX_END = VRAM_AW'(AUX_WORDS);

   cpu_state_e state_q, state_d;

   // Latched 68k request
   logic                rnw_q;
   logic [1:0]          sel_q;
   logic [VRAM_AW-1:0]  addr_q;
   logic [BW-1:0]       be_q;
   logic [DW-1:0]       din_q;
   logic [DW-1:0]       dout_q;
   logic [VRAM_AW-1:0]  cnt_q;

   // Renderer address registers (first stage of the 2-cycle pipe)
   logic [VRAM_AW-1:0]  vram_raddr_q;
   logic [AUX_AW-1:0]   sel_raddr_q;
   logic [AUX_AW-1:0]   scr_raddr_q;

   // Port B controls
   logic                vram_we, sel_we, scr_we;
   logic [VRAM_AW-1:0]  b_vaddr;
   logic [AUX_AW-1:0]   b_aaddr;
   logic [BW-1:0]       b_be;
   logic [DW-1:0]       b_din;
   logic [DW-1:0]       vram_bdout, sel_bdout, scr_bdout;
   logic [DW-1:0]       rd_mux;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge CLK96 or negedge RESET96_N) begin
      if (!RESET96_N) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (cpu.CPU_REQ) state_d = StAccess;
         StAccess: state_d = StWait;
         StWait:   state_d = StAck;
         StAck:    state_d = StHold;
         // A fresh access needs REQ to drop first.
         StHold:   if (!cpu.CPU_REQ) state_d = StIdle;
         StClear:  if (cnt_q == CNT_LAST) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      cpu.CPU_ACK = (state_q == StAck);
      CLEAR_BUSY  = (state_q == StClear);
      vram_we     = 1'b0;
      sel_we      = 1'b0;
      scr_we      = 1'b0;
      b_vaddr     = addr_q;
      b_aaddr     = addr_q[AUX_AW-1:0];
      b_be        = be_q;
      b_din       = din_q;
      unique case (state_q)
         StAccess: begin
            if (!rnw_q) begin
               unique case (sel_q)
                  SEL_VRAM:   vram_we = 1'b1;
                  SEL_SELECT: sel_we  = 1'b1;
                  SEL_SCROLL: scr_we  = 1'b1;
                  SEL_NONE:   ;
               endcase
            end
         end
         StClear: begin
            b_vaddr = cnt_q;
            b_aaddr = cnt_q[AUX_AW-1:0];
            b_be    = '1;
            b_din   = '0;
            vram_we = 1'b1;
            // The aux RAMs are only 256 deep; stop before the index wraps.
            sel_we  = (cnt_q < CNT_AUX_END);
            scr_we  = (cnt_q < CNT_AUX_END);
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------ datapath
   always_comb begin
      rd_mux = '0;
      unique case (sel_q)
         SEL_VRAM:   rd_mux = vram_bdout;
         SEL_SELECT: rd_mux = sel_bdout;
         SEL_SCROLL: rd_mux = scr_bdout;
         SEL_NONE:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge CLK96 or negedge RESET96_N) begin
      if (!RESET96_N) begin
         rnw_q  <= 1'b0;
         sel_q  <= SEL_VRAM;
         addr_q <= '0;
         be_q   <= '0;
         din_q  <= '0;
         dout_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (state_q == StIdle && cpu.CPU_REQ) begin
            rnw_q  <= cpu.CPU_RNW;
            sel_q  <= cpu.CPU_SEL;
            addr_q <= cpu.CPU_ADDR;
            be_q   <= cpu.CPU_BE;
            din_q  <= cpu.CPU_DIN;
         end
         if (state_q == StClear) begin
            cnt_q <= cnt_q + 1'b1;
         end
         // Port B output registered at the end of ACCESS is valid here.
         if (state_q == StWait) begin
            dout_q <= rnw_q ? rd_mux : '0;
         end
      end
   end

   assign cpu.CPU_DOUT = dout_q;

   always_ff @(posedge CLK96 or negedge RESET96_N) begin
      if (!RESET96_N) begin
         vram_raddr_q <= '0;
         sel_raddr_q  <= '0;
         scr_raddr_q  <= '0;
      end else begin
         vram_raddr_q <= TEXTVRAM_ADDR;
         sel_raddr_q  <= TEXTSELECT_ADDR;
         scr_raddr_q  <= TEXTSCROLL_ADDR;
      end
   end

   // ---------------------------------------------------------------- RAMs
   bakraid_bram_be #(
      .AW (VRAM_AW),
      .DW (DW)
   ) u_vram (
      .CLK96     (CLK96),
      .RESET96_N (RESET96_N),
      .a_we      (1'b0),
      .a_addr    (vram_raddr_q),
      .a_din     ('0),
      .a_dout    (TEXTVRAM_DATA),
      .b_we      (vram_we),
      .b_be      (b_be),
      .b_addr    (b_vaddr),
      .b_din     (b_din),
      .b_dout    (vram_bdout)
   );

   bakraid_bram_be #(
      .AW (AUX_AW),
      .DW (DW)
   ) u_select (
      .CLK96     (CLK96),
      .RESET96_N (RESET96_N),
      .a_we      (1'b0),
      .a_addr    (sel_raddr_q),
      .a_din     ('0),
      .a_dout    (TEXTSELECT_DATA),
      .b_we      (sel_we),
      .b_be      (b_be),
      .b_addr    (b_aaddr),
      .b_din     (b_din),
      .b_dout    (sel_bdout)
   );

   bakraid_bram_be #(
      .AW (AUX_AW),
      .DW (DW)
   ) u_scroll (
      .CLK96     (CLK96),
      .RESET96_N (RESET96_N),
      .a_we      (1'b0),
      .a_addr    (scr_raddr_q),
      .a_din     ('0),
      .a_dout    (TEXTSCROLL_DATA),
      .b_we      (scr_we),
      .b_be      (b_be),
      .b_addr    (b_aaddr),
      .b_din     (b_din),
      .b_dout    (scr_bdout)
   );

endmodule

// File: tb/tb_bakraid_textram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bakraid_textram_ctrl
//   Scoreboard bench for bakraid_textram_ctrl. Stimulus pushes expected CPU
//   acks and renderer words into queues; monitors pop and compare on the
//   falling clock edge. Memory contents are modelled with plain arrays.
// ----------------------------------------------------------------------------
module tb_bakraid_textram_ctrl;

   typedef struct {
      bit          rnw;
      logic [15:0] data;
      int          req_cyc;
      bit          in_clear;
   } cpu_exp_t;

   typedef struct {
      int          due;
      logic [15:0] data;
   } ren_exp_t;

   logic        CLK96 = 1'b0;
   logic        RESET96_N = 1'b0;
   logic [11:0] TEXTVRAM_ADDR = '0;
   logic [15:0] TEXTVRAM_DATA;
   logic [7:0]  TEXTSELECT_ADDR = '0;
   logic [15:0] TEXTSELECT_DATA;
   logic [7:0]  TEXTSCROLL_ADDR = '0;
   logic [15:0] TEXTSCROLL_DATA;
   logic        CLEAR_BUSY;

   bakraid_textram_ctrl_if bus ();

   bakraid_textram_ctrl dut (
      .CLK96           (CLK96),
      .RESET96_N       (RESET96_N),
      .TEXTVRAM_ADDR   (TEXTVRAM_ADDR),
      .TEXTVRAM_DATA   (TEXTVRAM_DATA),
      .TEXTSELECT_ADDR (TEXTSELECT_ADDR),
      .TEXTSELECT_DATA (TEXTSELECT_DATA),
      .TEXTSCROLL_ADDR (TEXTSCROLL_ADDR),
      .TEXTSCROLL_DATA (TEXTSCROLL_DATA),
      .cpu             (bus),
      .CLEAR_BUSY      (CLEAR_BUSY)
   );

   always #5 CLK96 = ~CLK96;

   int cyc = 0;
   always @(posedge CLK96) cyc <= cyc + 1;

   int tests = 0;
   int errors = 0;
   int ack_seen = 0;

   cpu_exp_t cpu_q[$];
   ren_exp_t vq[$], sq[$], cq[$];
   cpu_exp_t mon_e;
   ren_exp_t mon_r;

   // Reference contents of the three memories
   logic [15:0] m_vram [4096];
   logic [15:0] m_sel  [256];
   logic [15:0] m_scr  [256];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4096; i++) m_vram[i] = '0;
      for (int i = 0; i < 256; i++) begin
         m_sel[i] = '0;
         m_scr[i] = '0;
      end
   endtask

   function automatic logic [15:0] model_rd(input logic [1:0] sel, input logic [11:0] addr);
      case (sel)
         2'd0:    return m_vram[addr];
         2'd1:    return m_sel[addr[7:0]];
         2'd2:    return m_scr[addr[7:0]];
         default: return 16'h0000;
      endcase
   endfunction

   task automatic model_wr(input logic [1:0] sel, input logic [11:0] addr,
                           input logic [1:0] be, input logic [15:0] din);
      logic [15:0] mask;
      mask = {be[1] ? 8'hFF : 8'h00, be[0] ? 8'hFF : 8'h00};
      case (sel)
         2'd0: m_vram[addr]     = (m_vram[addr] & ~mask) | (din & mask);
         2'd1: m_sel[addr[7:0]] = (m_sel[addr[7:0]] & ~mask) | (din & mask);
         2'd2: m_scr[addr[7:0]] = (m_scr[addr[7:0]] & ~mask) | (din & mask);
         default: ;
      endcase
   endtask

   // One CPU transaction; called #1 after a rising edge, returns likewise.
   task automatic cpu_op(input bit rnw, input logic [1:0] sel, input logic [11:0] addr,
                         input logic [1:0] be, input logic [15:0] din, input int hold,
                         input bit in_clear, input int limit);
      cpu_exp_t e;
      bit acked;
      acked      = 1'b0;
      e.rnw      = rnw;
      e.data     = model_rd(sel, addr);
      e.req_cyc  = cyc;
      e.in_clear = in_clear;
      if (!rnw) model_wr(sel, addr, be, din);
      cpu_q.push_back(e);
      bus.CPU_RNW  = rnw;
      bus.CPU_SEL  = sel;
      bus.CPU_ADDR = addr;
      bus.CPU_BE   = be;
      bus.CPU_DIN  = din;
      bus.CPU_REQ  = 1'b1;
      for (int i = 0; i < limit; i++) begin
         @(posedge CLK96);
         #1;
         if (bus.CPU_ACK) begin
            acked = 1'b1;
            break;
         end
      end
      if (!acked) begin
         tests++;
         errors++;
         $display("FAIL ack_timeout: no ack within %0d cycles, required an ack", limit);
         cpu_q.delete();
      end
      repeat (hold) begin
         @(posedge CLK96);
         #1;
      end
      bus.CPU_REQ = 1'b0;
      repeat (2) begin
         @(posedge CLK96);
         #1;
      end
   endtask

   task automatic ren_vram(input logic [11:0] addr);
      ren_exp_t r;
      TEXTVRAM_ADDR = addr;
      r.due  = cyc + 2;
      r.data = m_vram[addr];
      vq.push_back(r);
      @(posedge CLK96);
      #1;
   endtask

   task automatic ren_drain();
      repeat (3) begin
         @(posedge CLK96);
         #1;
      end
   endtask

   // CPU ack monitor
   always @(negedge CLK96) begin
      if (RESET96_N && bus.CPU_ACK) begin
         ack_seen++;
         if (cpu_q.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL unexpected_ack: ack at cycle %0d, required none", cyc);
         end else begin
            mon_e = cpu_q.pop_front();
            if (mon_e.in_clear) chk("ack_after_clear_busy", 32'(CLEAR_BUSY), 32'd0);
            else chk("ack_latency", 32'(cyc - mon_e.req_cyc), 32'd3);
            if (mon_e.rnw) chk("cpu_dout", 32'(bus.CPU_DOUT), 32'(mon_e.data));
         end
      end
   end

   // Renderer monitors: each entry is due exactly two cycles after issue
   always @(negedge CLK96) begin
      if (RESET96_N) begin
         if (vq.size() > 0 && vq[0].due == cyc) begin
            mon_r = vq.pop_front();
            chk("ren_vram", 32'(TEXTVRAM_DATA), 32'(mon_r.data));
         end
         if (sq.size() > 0 && sq[0].due == cyc) begin
            mon_r = sq.pop_front();
            chk("ren_select", 32'(TEXTSELECT_DATA), 32'(mon_r.data));
         end
         if (cq.size() > 0 && cq[0].due == cyc) begin
            mon_r = cq.pop_front();
            chk("ren_scroll", 32'(TEXTSCROLL_DATA), 32'(mon_r.data));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt;
      int acks0;
      ren_exp_t r;
      bus.CPU_REQ  = 1'b0;
      bus.CPU_RNW  = 1'b1;
      bus.CPU_SEL  = '0;
      bus.CPU_ADDR = '0;
      bus.CPU_BE   = '0;
      bus.CPU_DIN  = '0;

      // Reset values
      repeat (3) @(posedge CLK96);
      @(negedge CLK96);
      chk("rst_vram_data", 32'(TEXTVRAM_DATA), 32'd0);
      chk("rst_select_data", 32'(TEXTSELECT_DATA), 32'd0);
      chk("rst_scroll_data", 32'(TEXTSCROLL_DATA), 32'd0);
      chk("rst_cpu_dout", 32'(bus.CPU_DOUT), 32'd0);
      chk("rst_cpu_ack", 32'(bus.CPU_ACK), 32'd0);
      chk("rst_clear_busy", 32'(CLEAR_BUSY), 32'd1);

      // Clear sweep length
      @(posedge CLK96);
      #1;
      RESET96_N = 1'b1;
      busy_cnt  = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge CLK96);
         if (CLEAR_BUSY) busy_cnt++;
         else break;
      end
      chk("clear_busy_cycles", 32'(busy_cnt), 32'd4096);
      model_clear();
      @(posedge CLK96);
      #1;

      ren_vram(12'hFFF);
      ren_drain();

      // Full write then renderer readback
      cpu_op(1'b0, 2'd0, 12'h123, 2'b11, 16'hBEEF, 0, 1'b0, 100);
      ren_vram(12'h123);
      ren_drain();

      // Low-byte write, CPU readback of merged word
      cpu_op(1'b0, 2'd0, 12'h123, 2'b01, 16'h1234, 0, 1'b0, 100);
      cpu_op(1'b1, 2'd0, 12'h123, 2'b11, 16'h0000, 0, 1'b0, 100);

      // Select RAM preload with data=addr, then back-to-back renderer sweep
      for (int i = 0; i < 256; i++) cpu_op(1'b0, 2'd1, 12'(i), 2'b11, 16'(i), 0, 1'b0, 100);
      for (int i = 0; i < 256; i++) begin
         TEXTSELECT_ADDR = 8'(i);
         r.due  = cyc + 2;
         r.data = m_sel[i];
         sq.push_back(r);
         @(posedge CLK96);
         #1;
      end
      ren_drain();

      // Unmapped region: write ignored, read returns zero, both acked
      cpu_op(1'b0, 2'd3, 12'h123, 2'b11, 16'hFFFF, 0, 1'b0, 100);
      cpu_op(1'b1, 2'd3, 12'h123, 2'b11, 16'h0000, 0, 1'b0, 100);
      cpu_op(1'b1, 2'd0, 12'h123, 2'b11, 16'h0000, 0, 1'b0, 100);

      // Empty byte-enable write leaves memory unchanged
      cpu_op(1'b0, 2'd0, 12'h123, 2'b00, 16'h0000, 0, 1'b0, 100);

      // REQ held high long after the ack: single ack pulse only
      acks0 = ack_seen;
      cpu_op(1'b1, 2'd0, 12'h123, 2'b11, 16'h0000, 10, 1'b0, 100);
      chk("single_ack_on_long_req", 32'(ack_seen - acks0), 32'd1);

      // Random CPU traffic across all regions
      for (int i = 0; i < 200; i++) begin
         cpu_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                12'($urandom_range(0, 4095)), 2'($urandom_range(0, 3)),
                16'($urandom), 0, 1'b0, 100);
      end

      // Random renderer reads on all three ports every cycle
      for (int i = 0; i < 100; i++) begin
         TEXTVRAM_ADDR   = 12'($urandom_range(0, 4095));
         TEXTSELECT_ADDR = 8'($urandom_range(0, 255));
         TEXTSCROLL_ADDR = 8'($urandom_range(0, 255));
         r.due = cyc + 2;
         r.data = m_vram[TEXTVRAM_ADDR];
         vq.push_back(r);
         r.data = m_sel[TEXTSELECT_ADDR];
         sq.push_back(r);
         r.data = m_scr[TEXTSCROLL_ADDR];
         cq.push_back(r);
         @(posedge CLK96);
         #1;
      end
      ren_drain();

      // Reset in the middle of a write: no ack may follow
      bus.CPU_RNW  = 1'b0;
      bus.CPU_SEL  = 2'd0;
      bus.CPU_ADDR = 12'h055;
      bus.CPU_BE   = 2'b11;
      bus.CPU_DIN  = 16'hAAAA;
      bus.CPU_REQ  = 1'b1;
      repeat (2) begin
         @(posedge CLK96);
         #1;
      end
      RESET96_N   = 1'b0;
      bus.CPU_REQ = 1'b0;
      @(negedge CLK96);
      chk("midreset_ack", 32'(bus.CPU_ACK), 32'd0);
      chk("midreset_clear_busy", 32'(CLEAR_BUSY), 32'd1);
      @(posedge CLK96);
      #1;
      RESET96_N = 1'b1;
      model_clear();

      // Request issued during the clear sweep is served once it ends
      cpu_op(1'b1, 2'd0, 12'h055, 2'b11, 16'h0000, 0, 1'b1, 6000);
      chk("clear_done", 32'(CLEAR_BUSY), 32'd0);
      ren_vram(12'h055);
      ren_vram(12'h123);
      ren_drain();

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/bakraid_textram_ctrl.md
Name: bakraid_textram_ctrl

Overview:
- Owns the three text-layer memories: text VRAM (4096x16), text select RAM (256x16) and text scroll RAM (256x16).
- Acts as the responder on the renderer side. It serves the extra-text line renderer's address/data ports with a fixed 2-cycle read latency.
- Services 68k-side reads and writes through a REQ/ACK handshake with byte enables.
- Runs a power-up clear sweep so the renderer never sees stale contents.

Parameters:
- VRAM_AW, 12, text VRAM word-address width.
- AUX_AW, 8, select/scroll RAM word-address width.
- DW, 16, data width.
- CLEAR_ON_RESET, 1, when 1 run the clear sweep after reset release.

Ports:
- CLK96  in  1  system clock; every register is on its rising edge.
- RESET96_N  in  1  reset: asynchronous assert, active-low.
- TEXTVRAM_ADDR  in  12  renderer VRAM word address.
- TEXTVRAM_DATA  out  16  VRAM read data, 2 cycles after the address.
- TEXTSELECT_ADDR  in  8  renderer select-RAM address.
- TEXTSELECT_DATA  out  16  select data, 2-cycle latency.
- TEXTSCROLL_ADDR  in  8  renderer scroll-RAM address.
- TEXTSCROLL_DATA  out  16  scroll data, 2-cycle latency.
- CPU_REQ  in  1  level request, held until CPU_ACK.
- CPU_RNW  in  1  1=read, 0=write.
- CPU_SEL  in  2  region: 0 VRAM, 1 select, 2 scroll, 3 unmapped.
- CPU_ADDR  in  12  word address; select/scroll use [7:0].
- CPU_BE  in  2  byte enables [1]=D15:8, [0]=D7:0.
- CPU_DIN  in  16  write data.
- CPU_DOUT  out  16  read data, valid while CPU_ACK=1.
- CPU_ACK  out  1  one-cycle acknowledge (DTACK source).
- CLEAR_BUSY  out  1  high while the clear sweep runs.

Behaviour:
- Reset values while RESET96_N=0:
  - All *_DATA outputs, CPU_DOUT and CPU_ACK are 0.
  - CLEAR_BUSY = CLEAR_ON_RESET.
  - FSM is in CLEAR if CLEAR_ON_RESET, else IDLE; the clear counter is 0.
- Renderer port:
  - Always served; it has absolute priority and is never stalled.
  - Address is registered in cycle N, the RAM output is registered in N+1, and data appears on the output at N+2.
  - Throughput is one address per cycle.
- CPU port: a second RAM port, independent of the renderer port. FSM states:
  - IDLE: wait for CPU_REQ=1; latch RNW, SEL, ADDR, BE and DIN; go to ACCESS.
  - ACCESS: drive port B. A write applies BE-masked bytes this cycle. A read issues the address. Go to WAIT.
  - WAIT: read data registers. Go to ACK.
  - ACK: CPU_ACK=1 for exactly one cycle. For reads, CPU_DOUT holds the data. Go to HOLD.
  - HOLD: wait for CPU_REQ=0, then go to IDLE. No second access is taken without a REQ low phase.
  - CLEAR: write 0 to VRAM[cnt] and to select/scroll[cnt[7:0]] while cnt<256. cnt increments 0..4095. At 4095, clear CLEAR_BUSY and go to IDLE.
- Timing: REQ to ACK is 3 cycles after REQ is sampled, for both reads and writes.
- Boundary rules:
  - CPU_BE=00 write: acked, memory unchanged.
  - CPU_SEL=3: write ignored, read returns 0x0000, still acked.
  - CPU write and renderer read to the same address in the same cycle: the renderer gets old data. Read-during-write on port A is old data.
  - CPU_REQ arriving during CLEAR is held off and not acked until the clear completes. It is then serviced from IDLE.
  - Renderer reads during CLEAR return the current RAM contents; no gating.
  - Reset asserted mid-access: FSM restarts. A write already applied in ACCESS persists. The ack is never issued.
  - Address widths are exact; there is no wrap logic beyond the natural truncation of CPU_ADDR[7:0] for the aux RAMs.

Decomposition:
- Shared package bakraid_text_pkg holds:
  - region constants SEL_VRAM=0, SEL_SELECT=1, SEL_SCROLL=2, SEL_NONE=3;
  - VRAM_WORDS=4096, AUX_WORDS=256;
  - the CPU FSM state enum.
- One sub-module: bakraid_bram_be. It is a true dual-port RAM with AW/DW parameters, registered output on both ports, byte enables on port B, and old-data read-during-write. It is instantiated three times.

Test Plan:
- Release reset with CLEAR_ON_RESET=1 -> CLEAR_BUSY high for 4096 cycles, then 0. Renderer read of VRAM 0x0FFF returns 0x0000.
- CPU write SEL=0, ADDR=0x123, BE=11, DIN=0xBEEF -> ACK 3 cycles after REQ. Renderer drives 0x123 at cycle N -> TEXTVRAM_DATA=0xBEEF at N+2.
- After the previous write, CPU write BE=01, DIN=0x1234 to 0x123 -> a CPU read returns 0xBE34 with ACK and CPU_DOUT=0xBE34.
- Renderer address sweep 0x00..0xFF on the select RAM, preloaded with data=addr -> TEXTSELECT_DATA follows with exactly 2-cycle lag, one word per cycle.
- CPU SEL=3 write of 0xFFFF followed by a read -> both acked, read returns 0x0000, no RAM changes.
- REQ held high for 10 cycles -> exactly one ACK pulse. Issue REQ during CLEAR -> ACK only after CLEAR_BUSY falls.
